// File: rtl/eau_sequencer.sv
// Round-robin sequencer sharing the external address unit (Eau) between two requesters.
// Captures the granted address, loads it bytewise or as a word, holds the address phase, then acks.
module eau_sequencer #(
  parameter int unsigned ADDR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wide0,
  input  logic        wide1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic [7:0]  eau_d,
  output logic [15:0] eau_a,
  output logic        eau_di,
  output logic        eau_ls,
  output logic        eau_hs,
  output logic        eau_ai,
  output logic        eau_ao,
  output logic        eau_do,
  output logic        eau_rst
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADDR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_LOAD_W,
    S_ADDR,
    S_ACK
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               r_owner;
  logic               w_owner_nxt;
  logic               r_ptr;
  logic               w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_grant;
  logic               w_sel_wide;
  logic [ADDR_W-1:0]  w_sel_addr;

  logic               r_gnt0, r_gnt1, r_ack0, r_ack1, r_busy;
  logic               r_eau_di, r_eau_ls, r_eau_hs, r_eau_ai, r_eau_ao, r_eau_rst;
  logic [BYTE_W-1:0]  r_eau_d;
  logic [ADDR_W-1:0]  r_eau_a;

  logic               w_gnt0, w_gnt1, w_ack0, w_ack1, w_busy;
  logic               w_eau_di, w_eau_ls, w_eau_hs, w_eau_ai, w_eau_ao, w_eau_rst;
  logic [BYTE_W-1:0]  w_eau_d;
  logic [ADDR_W-1:0]  w_eau_a;
  logic               w_owned;

  // On contention the pointer names the preferred requester; a lone request always wins.
  assign w_grant    = (req0 && req1) ? r_ptr : req1;
  assign w_sel_wide = w_grant ? wide1 : wide0;
  assign w_sel_addr = w_grant ? addr1 : addr0;

  // Next state plus output decode; outputs are decoded from the next-state registers so they
  // land in flops on the same edge as the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;

    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_ack0    = 1'b0;
    w_ack1    = 1'b0;
    w_busy    = 1'b0;
    w_eau_di  = 1'b0;
    w_eau_ls  = 1'b0;
    w_eau_hs  = 1'b0;
    w_eau_ai  = 1'b0;
    w_eau_ao  = 1'b0;
    w_eau_rst = 1'b0;
    w_eau_d   = '0;
    w_eau_a   = '0;
    w_owned   = 1'b0;

    unique case (r_state)
      S_INIT: w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner_nxt = w_grant;
          w_addr_nxt  = w_sel_addr;
          w_ptr_nxt   = ~w_grant;
          w_state_nxt = w_sel_wide ? S_LOAD_W : S_LOAD_LO;
        end
      end
      S_LOAD_LO: w_state_nxt = S_LOAD_HI;
      S_LOAD_HI, S_LOAD_W: begin
        w_state_nxt = S_ADDR;
        w_cnt_nxt   = CNT_LOAD;
      end
      S_ADDR: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase

    unique case (w_state_nxt)
      S_INIT: begin
        w_busy    = 1'b1;
        w_eau_rst = 1'b1;
      end
      S_LOAD_LO: begin
        w_owned  = 1'b1;
        w_eau_di = 1'b1;
        w_eau_ls = 1'b1;
        w_eau_d  = w_addr_nxt[BYTE_W-1:0];
      end
      S_LOAD_HI: begin
        w_owned  = 1'b1;
        w_eau_di = 1'b1;
        w_eau_hs = 1'b1;
        w_eau_d  = w_addr_nxt[ADDR_W-1:BYTE_W];
      end
      S_LOAD_W: begin
        w_owned  = 1'b1;
        w_eau_ai = 1'b1;
        w_eau_a  = w_addr_nxt;
      end
      S_ADDR: begin
        w_owned  = 1'b1;
        w_eau_ao = 1'b1;
      end
      S_ACK: begin
        w_owned = 1'b1;
        w_ack0  = ~w_owner_nxt;
        w_ack1  = w_owner_nxt;
      end
      default: ;
    endcase

    if (w_owned) begin
      w_busy = 1'b1;
      w_gnt0 = ~w_owner_nxt;
      w_gnt1 = w_owner_nxt;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_addr    <= '0;
      r_owner   <= 1'b0;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b1;
      r_eau_di  <= 1'b0;
      r_eau_ls  <= 1'b0;
      r_eau_hs  <= 1'b0;
      r_eau_ai  <= 1'b0;
      r_eau_ao  <= 1'b0;
      r_eau_rst <= 1'b1;
      r_eau_d   <= '0;
      r_eau_a   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_ack0    <= w_ack0;
      r_ack1    <= w_ack1;
      r_busy    <= w_busy;
      r_eau_di  <= w_eau_di;
      r_eau_ls  <= w_eau_ls;
      r_eau_hs  <= w_eau_hs;
      r_eau_ai  <= w_eau_ai;
      r_eau_ao  <= w_eau_ao;
      r_eau_rst <= w_eau_rst;
      r_eau_d   <= w_eau_d;
      r_eau_a   <= w_eau_a;
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign busy    = r_busy;
  assign eau_d   = r_eau_d;
  assign eau_a   = r_eau_a;
  assign eau_di  = r_eau_di;
  assign eau_ls  = r_eau_ls;
  assign eau_hs  = r_eau_hs;
  assign eau_ai  = r_eau_ai;
  assign eau_ao  = r_eau_ao;
  assign eau_do  = 1'b0;
  assign eau_rst = r_eau_rst;

endmodule

// File: tb/tb_eau_sequencer.sv
// Bench for eau_sequencer: directed vector table, contention/order sequence, and random traffic
// checked against a transaction-trace model, on instances with ADDR_CYCLES=2 and ADDR_CYCLES=1.
module tb_eau_sequencer;

  typedef struct packed {
    logic        er;
    logic        busy;
    logic        g0;
    logic        g1;
    logic        k0;
    logic        k1;
    logic        di;
    logic        ls;
    logic        hs;
    logic        ai;
    logic        ao;
    logic        dz;
    logic [7:0]  d;
    logic [15:0] a;
  } ov_t;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        r1;
    logic        w0;
    logic        w1;
    logic [15:0] a0;
    logic [15:0] a1;
    ov_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, req0, req1, wide0, wide1;
  logic [15:0] addr0, addr1;

  logic o_g0[2], o_g1[2], o_k0[2], o_k1[2], o_busy[2];
  logic o_di[2], o_ls[2], o_hs[2], o_ai[2], o_ao[2], o_do[2], o_er[2];
  logic [7:0]  o_d[2];
  logic [15:0] o_a[2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: expected output trace of the transaction in flight.
  ov_t  tr[2][32];
  int   tlen[2];
  int   tpos[2];
  logic mptr[2];
  logic minit[2];

  vec_t tbl[$];

  always #5 clk = ~clk;

  eau_sequencer #(.ADDR_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wide0(wide0), .wide1(wide1),
    .addr0(addr0), .addr1(addr1), .gnt0(o_g0[0]), .gnt1(o_g1[0]), .ack0(o_k0[0]),
    .ack1(o_k1[0]), .busy(o_busy[0]), .eau_d(o_d[0]), .eau_a(o_a[0]), .eau_di(o_di[0]),
    .eau_ls(o_ls[0]), .eau_hs(o_hs[0]), .eau_ai(o_ai[0]), .eau_ao(o_ao[0]),
    .eau_do(o_do[0]), .eau_rst(o_er[0])
  );

  eau_sequencer #(.ADDR_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wide0(wide0), .wide1(wide1),
    .addr0(addr0), .addr1(addr1), .gnt0(o_g0[1]), .gnt1(o_g1[1]), .ack0(o_k0[1]),
    .ack1(o_k1[1]), .busy(o_busy[1]), .eau_d(o_d[1]), .eau_a(o_a[1]), .eau_di(o_di[1]),
    .eau_ls(o_ls[1]), .eau_hs(o_hs[1]), .eau_ai(o_ai[1]), .eau_ao(o_ao[1]),
    .eau_do(o_do[1]), .eau_rst(o_er[1])
  );

  function automatic ov_t v_idle();
    ov_t v = '0;
    return v;
  endfunction

  function automatic ov_t v_init();
    ov_t v = '0;
    v.er = 1'b1; v.busy = 1'b1;
    return v;
  endfunction

  function automatic ov_t v_own(logic o);
    ov_t v = '0;
    v.busy = 1'b1; v.g0 = ~o; v.g1 = o;
    return v;
  endfunction

  function automatic ov_t v_lo(logic o, logic [7:0] b);
    ov_t v = v_own(o);
    v.di = 1'b1; v.ls = 1'b1; v.d = b;
    return v;
  endfunction

  function automatic ov_t v_hi(logic o, logic [7:0] b);
    ov_t v = v_own(o);
    v.di = 1'b1; v.hs = 1'b1; v.d = b;
    return v;
  endfunction

  function automatic ov_t v_w(logic o, logic [15:0] x);
    ov_t v = v_own(o);
    v.ai = 1'b1; v.a = x;
    return v;
  endfunction

  function automatic ov_t v_ao(logic o);
    ov_t v = v_own(o);
    v.ao = 1'b1;
    return v;
  endfunction

  function automatic ov_t v_ack(logic o);
    ov_t v = v_own(o);
    v.k0 = ~o; v.k1 = o;
    return v;
  endfunction

  function automatic ov_t pack(int k);
    ov_t v;
    v.er = o_er[k]; v.busy = o_busy[k]; v.g0 = o_g0[k]; v.g1 = o_g1[k];
    v.k0 = o_k0[k]; v.k1 = o_k1[k]; v.di = o_di[k]; v.ls = o_ls[k]; v.hs = o_hs[k];
    v.ai = o_ai[k]; v.ao = o_ao[k]; v.dz = o_do[k]; v.d = o_d[k]; v.a = o_a[k];
    return v;
  endfunction

  // Expected outputs after one clock edge given the inputs present at that edge.
  function automatic ov_t model_step(int k, int n);
    logic g, w;
    logic [15:0] ad;
    if (rst) begin
      tlen[k] = 0; tpos[k] = 0; mptr[k] = 1'b0; minit[k] = 1'b1;
      return v_init();
    end
    if (minit[k]) begin
      minit[k] = 1'b0;
      return v_idle();
    end
    if (tpos[k] < tlen[k]) begin
      tpos[k]++;
      return tr[k][tpos[k]-1];
    end
    if (!(req0 || req1)) return v_idle();
    g = (req0 && req1) ? mptr[k] : req1;
    mptr[k] = ~g;
    ad = g ? addr1 : addr0;
    w  = g ? wide1 : wide0;
    tlen[k] = 0;
    if (w) begin
      tr[k][tlen[k]++] = v_w(g, ad);
    end else begin
      tr[k][tlen[k]++] = v_lo(g, ad[7:0]);
      tr[k][tlen[k]++] = v_hi(g, ad[15:8]);
    end
    for (int i = 0; i < n; i++) tr[k][tlen[k]++] = v_ao(g);
    tr[k][tlen[k]++] = v_ack(g);
    tr[k][tlen[k]++] = v_idle();
    tpos[k] = 1;
    return tr[k][0];
  endfunction

  task automatic check(input string name, input ov_t act, input ov_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    ov_t e;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = model_step(k, (k == 0) ? 2 : 1);
      check((k == 0) ? "model_ac2" : "model_ac1", pack(k), e);
    end
  endtask

  function automatic void add(logic r, logic r0, logic r1, logic w0, logic w1,
                              logic [15:0] a0, logic [15:0] a1, ov_t e);
    vec_t v;
    v.rst = r; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    int   order[$];
    logic pg0, pg1;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wide0 = 1'b0; wide1 = 1'b0;
    addr0 = '0; addr1 = '0;
    for (int k = 0; k < 2; k++) begin
      tlen[k] = 0; tpos[k] = 0; mptr[k] = 1'b0; minit[k] = 1'b1;
    end

    // Directed vectors, expectations for the ADDR_CYCLES=2 instance.
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, v_init());
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, v_init());
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, v_idle());
    add(0, 1, 0, 0, 0, 16'h14F1, 16'h0000, v_lo(0, 8'hF1));
    add(0, 0, 0, 0, 0, 16'h14F1, 16'h0000, v_hi(0, 8'h14));
    add(0, 0, 0, 0, 0, 16'h14F1, 16'h0000, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h14F1, 16'h0000, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h14F1, 16'h0000, v_ack(0));
    add(0, 0, 0, 0, 0, 16'h14F1, 16'h0000, v_idle());
    add(0, 0, 1, 0, 1, 16'h0000, 16'hBEEF, v_w(1, 16'hBEEF));
    add(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, v_ao(1));
    add(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, v_ao(1));
    add(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, v_ack(1));
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, v_idle());
    add(0, 1, 0, 0, 0, 16'hA55A, 16'h0000, v_lo(0, 8'h5A));
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, v_hi(0, 8'hA5));
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, v_ack(0));
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, v_idle());
    add(0, 1, 0, 0, 0, 16'h1234, 16'h0000, v_lo(0, 8'h34));
    add(0, 1, 1, 0, 0, 16'h1234, 16'h0000, v_hi(0, 8'h12));
    add(0, 1, 1, 0, 0, 16'h1234, 16'h0000, v_ao(0));
    add(1, 1, 1, 0, 0, 16'h1234, 16'h0000, v_init());
    add(0, 1, 1, 0, 0, 16'h0F0F, 16'h7777, v_idle());
    add(0, 1, 1, 0, 0, 16'h0F0F, 16'h7777, v_lo(0, 8'h0F));
    add(0, 0, 0, 0, 0, 16'h0F0F, 16'h7777, v_hi(0, 8'h0F));
    add(0, 0, 0, 0, 0, 16'h0F0F, 16'h7777, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h0F0F, 16'h7777, v_ao(0));
    add(0, 0, 0, 0, 0, 16'h0F0F, 16'h7777, v_ack(0));
    add(0, 0, 0, 0, 0, 16'h0F0F, 16'h7777, v_idle());

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      wide0 = tbl[i].w0; wide1 = tbl[i].w1; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      tick();
      check($sformatf("vec%0d", i), pack(0), tbl[i].exp);
    end

    // Contention: both requests held from reset release; grants must alternate 0,1,0,1.
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wide0 = 1'b0; wide1 = 1'b1;
    addr0 = 16'h1111; addr1 = 16'h2222;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    pg0 = 1'b0; pg1 = 1'b0;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (o_g0[0] && !pg0) order.push_back(0);
      if (o_g1[0] && !pg1) order.push_back(1);
      pg0 = o_g0[0]; pg1 = o_g1[0];
      n_checks++;
      if (o_g0[0] && o_g1[0]) begin
        n_fail++;
        $display("FAIL gnt_onehot @%0t: got gnt0=%b gnt1=%b expected not both 1",
                 $time, o_g0[0], o_g1[0]);
      end
    end
    n_checks++;
    if (order.size() < 4) begin
      n_fail++;
      $display("FAIL grant_count: got %0d grants expected at least 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (order[i] != (i % 2)) begin
          n_fail++;
          $display("FAIL grant_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
        end
      end
    end

    // Random traffic, including mid-transaction resets and input changes after grant.
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      wide0 = $urandom_range(0, 1) == 1;
      wide1 = $urandom_range(0, 1) == 1;
      addr0 = 16'($urandom());
      addr1 = 16'($urandom());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
